video_frontend: RTL
===================

Name: video_frontend

Overview:
- Upstream stage of the graphics compositor. Generates 1280x720 raster timing (hcount/vcount) that drives the compositor's counters.
- Snapshots asynchronous-rate game state (player/opponent position, direction) once per frame during vertical blank, so every pixel of a frame is rendered from one consistent state.
- Delays hsync/vsync/active by the compositor's pixel latency so HDMI/VGA output sees sync aligned with pixel_out.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, visible lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- PIPE_DEPTH, 9, cycles from hcount_out/vcount_out to the compositor's registered pixel_out

Ports:
- clk_in  in  1  pixel clock (74.25 MHz)
- rst_in  in  1  asynchronous reset, active-low
- state_valid_in  in  1  one-cycle strobe: the game-state inputs below are valid this cycle
- player_x_in  in  11  player x
- player_y_in  in  11  player y
- opponent_x_in  in  11  opponent x
- opponent_y_in  in  11  opponent y
- direction_in  in  9  player heading
- hcount_out  out  11  horizontal counter, 0..H_TOTAL-1
- vcount_out  out  10  vertical counter, 0..V_TOTAL-1
- player_x  out  11  frame-stable snapshot
- player_y  out  11  frame-stable snapshot
- opponent_x  out  11  frame-stable snapshot
- opponent_y  out  11  frame-stable snapshot
- direction  out  9  frame-stable snapshot
- new_frame_out  out  1  one-cycle pulse at the commit cycle
- frame_count_out  out  16  frames committed since reset, wraps
- hsync_out  out  1  delayed, active-high
- vsync_out  out  1  delayed, active-high
- active_out  out  1  delayed, high in visible region

Behaviour:
- Definitions: H_TOTAL = sum of the H params (1650); V_TOTAL = sum of the V params (750).
- Reset (rst_in low, async): all outputs 0, pending registers 0, pending_valid 0, delay lines cleared. The first cycle after release shows hcount_out=0, vcount_out=0.
- Counters:
  - hcount_out increments every cycle and wraps H_TOTAL-1 -> 0.
  - vcount_out increments when hcount_out wraps, and wraps V_TOTAL-1 -> 0.
- Undelayed sync and active signals, computed from the current counters:
  - hs_raw = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_raw = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - act_raw = hcount<H_ACTIVE and vcount<V_ACTIVE
- Alignment: hsync_out/vsync_out/active_out equal the raw values PIPE_DEPTH cycles earlier, via a shift register. During the first PIPE_DEPTH cycles after reset they read 0.
- Pending capture: on state_valid_in, all five inputs are written to pending registers and pending_valid is set. With multiple strobes in one frame, the last one wins.
- Commit cycle: the cycle in which the counters equal (hcount=0, vcount=V_ACTIVE), i.e. the start of vblank.
  - new_frame_out is high for exactly that cycle.
  - frame_count_out increments.
  - If pending_valid, the pending values are copied to the snapshot outputs and pending_valid is cleared. Otherwise the snapshot outputs hold.
- Strobe on the commit cycle: the commit uses pending contents from before this cycle. The new strobe's values become pending for the next frame, and pending_valid ends the cycle set.
- Snapshot outputs never change outside the commit cycle.
- frame_count_out wraps 0xFFFF -> 0.
- Reset asserted mid-frame: counters, snapshot and delay lines clear immediately. No partial commit.

Decomposition:
- Shared package video_pkg holds:
  - the timing constants (720p set)
  - a typedef game_state_t packing {player_x, player_y, opponent_x, opponent_y, direction} (53 bits), so pending and snapshot are one register each.
- Sub-module delay_line (params WIDTH, DEPTH; async active-low reset clears it) instantiated once with WIDTH=3 for {hs, vs, act}.

Test Plan:
- Reset release, run 1650*750 cycles -> hcount_out wraps after 1649, vcount_out after 749. new_frame_out pulses once per frame at (0,720). frame_count_out = 1 after the first commit.
- Raw sync check -> hsync_out high for 40 cycles starting 1390+9 cycles after the hcount=0 cycle; vsync_out high for lines 725..729 (shifted 9 cycles); active_out high 1280 cycles per visible line.
- state_valid_in with player_x_in=300 at line 100 -> player_x stays 0 until the commit cycle, then reads 300 and holds through the next frame.
- Strobes with x=10 at line 200 and x=20 at line 400, same frame -> player_x=20 after commit. Strobe x=30 exactly on the commit cycle -> player_x stays 20 for that frame and becomes 30 at the next commit.
- No strobe for 3 frames -> snapshot unchanged and frame_count_out still increments by 3.
- Assert rst_in low at hcount=700, vcount=300 -> all outputs 0 within the same cycle (async). After release, counting restarts from (0,0).

Source files
------------

// File: rtl/video_pkg.sv
// Shared timing constants and the game-state record for the video front end.
package video_pkg;

  // 1280x720 @ 60 Hz raster timing with a 74.25 MHz pixel clock.
  localparam int HD720_H_ACTIVE   = 1280;
  localparam int HD720_H_FP       = 110;
  localparam int HD720_H_SYNC     = 40;
  localparam int HD720_H_BP       = 220;
  localparam int HD720_V_ACTIVE   = 720;
  localparam int HD720_V_FP       = 5;
  localparam int HD720_V_SYNC     = 5;
  localparam int HD720_V_BP       = 20;
  localparam int HD720_PIPE_DEPTH = 9;

  // One complete game state, 53 bits, held in a single register.
  typedef struct packed {
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [10:0] opponent_x;
    logic [10:0] opponent_y;
    logic [8:0]  direction;
  } game_state_t;

endpackage

// File: rtl/video_frontend_delay_line.sv
// Fixed-latency shift register used to line sync/active up with pixel data.
module delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_p [DEPTH];

  // Shift one stage per clock; reset empties every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/video_frontend.sv
// Raster timing generator, once-per-frame game-state snapshot, and sync
// delay matched to the compositor's pixel latency.
module video_frontend
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = video_pkg::HD720_H_ACTIVE,
  parameter int H_FP       = video_pkg::HD720_H_FP,
  parameter int H_SYNC     = video_pkg::HD720_H_SYNC,
  parameter int H_BP       = video_pkg::HD720_H_BP,
  parameter int V_ACTIVE   = video_pkg::HD720_V_ACTIVE,
  parameter int V_FP       = video_pkg::HD720_V_FP,
  parameter int V_SYNC     = video_pkg::HD720_V_SYNC,
  parameter int V_BP       = video_pkg::HD720_V_BP,
  parameter int PIPE_DEPTH = video_pkg::HD720_PIPE_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        state_valid_in,
  input  logic [10:0] player_x_in,
  input  logic [10:0] player_y_in,
  input  logic [10:0] opponent_x_in,
  input  logic [10:0] opponent_y_in,
  input  logic [8:0]  direction_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [10:0] player_x,
  output logic [10:0] player_y,
  output logic [10:0] opponent_x,
  output logic [10:0] opponent_y,
  output logic [8:0]  direction,
  output logic        new_frame_out,
  output logic [15:0] frame_count_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hs_raw;
  logic        vs_raw;
  logic        act_raw;
  logic [2:0]  sync_dly;
  logic        commit;
  logic        pending_valid;
  logic [15:0] frame_count;
  game_state_t strobe_state;
  game_state_t pending;
  game_state_t snapshot;

  // Raster counters: hcount every pixel, vcount on each line wrap.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign hs_raw  = (hcount >= HS_START) && (hcount < HS_END);
  assign vs_raw  = (vcount >= VS_START) && (vcount < VS_END);
  assign act_raw = (hcount < H_VIS) && (vcount < V_VIS);

  // Sync/active leave PIPE_DEPTH cycles late so they meet pixel_out.
  delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DEPTH)
  ) u_sync_dly (
    .clk   (clk_in),
    .rst_n (rst_in),
    .din   ({hs_raw, vs_raw, act_raw}),
    .dout  (sync_dly)
  );

  assign {hsync_out, vsync_out, active_out} = sync_dly;

  // First pixel of vertical blank: the only point the visible state may move.
  assign commit = (hcount == '0) && (vcount == V_VIS);

  assign strobe_state = {player_x_in, player_y_in, opponent_x_in,
                         opponent_y_in, direction_in};

  // Latest strobe in a frame overwrites any earlier one.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pending <= '0;
    else if (state_valid_in) pending <= strobe_state;
  end

  // A strobe on the commit cycle re-arms for the following frame.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pending_valid <= 1'b0;
    else if (state_valid_in) pending_valid <= 1'b1;
    else if (commit) pending_valid <= 1'b0;
  end

  // Snapshot takes the pending state as it stood before the commit cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) snapshot <= '0;
    else if (commit && pending_valid) snapshot <= pending;
  end

  // Free-running count of commits, wrapping naturally at 16 bits.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) frame_count <= '0;
    else if (commit) frame_count <= frame_count + 16'd1;
  end

  assign hcount_out      = hcount;
  assign vcount_out      = vcount;
  assign new_frame_out   = commit;
  assign frame_count_out = frame_count;
  assign player_x        = snapshot.player_x;
  assign player_y        = snapshot.player_y;
  assign opponent_x      = snapshot.opponent_x;
  assign opponent_y      = snapshot.opponent_y;
  assign direction       = snapshot.direction;

endmodule
